// File: rtl/counter_cmd_arbiter_if.sv
// rtl/counter_cmd_arbiter_if.sv - requester and counter-side signal bundle for counter_cmd_arbiter
//
// Ports (slave = arbiter side, master = requesters + counter side):
//   Req0/Req1, Op0/Op1, Arg0/Arg1   command requests (00 LOAD, 01 UP, 10 DOWN, 11 NOP)
//   Gnt0/Gnt1                       one-cycle accept pulses
//   Busy, Done, Done_Id, Sat, Result command status and completion report
//   Cnt_In, Cnt_Load, Cnt_Up, Cnt_Down  drive to the counter
//   Cnt_Value, Cnt_High, Cnt_Low    counter state and flags
interface counter_cmd_arbiter_if #(
  parameter int WIDTH = 5
);
  logic             Req0;
  logic             Req1;
  logic [1:0]       Op0;
  logic [1:0]       Op1;
  logic [WIDTH-1:0] Arg0;
  logic [WIDTH-1:0] Arg1;
  logic             Gnt0;
  logic             Gnt1;
  logic             Busy;
  logic             Done;
  logic             Done_Id;
  logic             Sat;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Cnt_In;
  logic             Cnt_Load;
  logic             Cnt_Up;
  logic             Cnt_Down;
  logic [WIDTH-1:0] Cnt_Value;
  logic             Cnt_High;
  logic             Cnt_Low;

  modport slave (
    input  Req0, Req1, Op0, Op1, Arg0, Arg1, Cnt_Value, Cnt_High, Cnt_Low,
    output Gnt0, Gnt1, Busy, Done, Done_Id, Sat, Result,
           Cnt_In, Cnt_Load, Cnt_Up, Cnt_Down
  );

  modport master (
    output Req0, Req1, Op0, Op1, Arg0, Arg1, Cnt_Value, Cnt_High, Cnt_Low,
    input  Gnt0, Gnt1, Busy, Done, Done_Id, Sat, Result,
           Cnt_In, Cnt_Load, Cnt_Up, Cnt_Down
  );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// rtl/counter_cmd_arbiter.sv - round-robin command sequencer driving a WIDTH-bit up/down counter
//
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset; also gates all Cnt_* outputs in its cycle
//   bus    counter_cmd_arbiter_if.slave (requests, grants, status, counter pins)
// Optional feature macro: CNT_ARB_WRAP_EN (wrap through 0 / all-ones instead of
// stopping when the counter reaches High/Low).
module counter_cmd_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  counter_cmd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_arg;
  logic [WIDTH-1:0] r_rem;
  logic             r_id;
  logic             r_ptr;
  logic             r_first;
  logic             r_sat;

  logic             w_any;
  logic             w_win;
  logic             w_updn;
  logic             w_rem_nz;
  logic             w_lim;
  logic             w_step;
  logic             w_sat_end;

  assign w_any    = bus.Req0 | bus.Req1;
  // On contention the requester that was not granted last wins.
  assign w_win    = (bus.Req0 && bus.Req1) ? ~r_ptr : bus.Req1;
  assign w_updn   = (r_op == OP_UP) || (r_op == OP_DOWN);
  assign w_rem_nz = (r_rem != '0);
  assign w_lim    = (r_op == OP_UP) ? bus.Cnt_High : bus.Cnt_Low;

`ifdef CNT_ARB_WRAP_EN
  // At the limit the step becomes a wrap-around load, so every step is issued.
  assign w_step    = w_updn && w_rem_nz;
  assign w_sat_end = 1'b0;
`else
  assign w_step    = w_updn && w_rem_nz && !w_lim;
  assign w_sat_end = w_updn && w_rem_nz && w_lim;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // EXEC ends after any non-stepping cycle (LOAD, NOP, N=0, saturation)
  // or after the step that consumes the last remaining count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_EXEC;
      S_EXEC:  if (!w_step || (r_rem == WIDTH'(1))) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op    <= 2'b11;
      r_arg   <= '0;
      r_rem   <= '0;
      r_id    <= 1'b0;
      r_ptr   <= 1'b1;
      r_first <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_first <= (r_state == S_IDLE) && w_any;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_id  <= w_win;
          r_ptr <= w_win;
          r_op  <= w_win ? bus.Op1 : bus.Op0;
          r_arg <= w_win ? bus.Arg1 : bus.Arg0;
          r_rem <= w_win ? bus.Arg1 : bus.Arg0;
          r_sat <= 1'b0;
        end
        S_EXEC: begin
          if (w_step)    r_rem <= r_rem - WIDTH'(1);
          if (w_sat_end) r_sat <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Busy     = (r_state != S_IDLE);
    bus.Gnt0     = (r_state == S_EXEC) && r_first && !r_id;
    bus.Gnt1     = (r_state == S_EXEC) && r_first && r_id;
    bus.Done     = (r_state == S_DONE);
    bus.Done_Id  = (r_state == S_DONE) && r_id;
    bus.Sat      = (r_state == S_DONE) && r_sat;
    bus.Result   = (r_state == S_DONE) ? bus.Cnt_Value : '0;
    bus.Cnt_In   = '0;
    bus.Cnt_Load = 1'b0;
    bus.Cnt_Up   = 1'b0;
    bus.Cnt_Down = 1'b0;
    // Reset gates the counter pins in the same cycle so an aborted command
    // cannot leave one extra step behind.
    if ((r_state == S_EXEC) && !i_rst) begin
      case (r_op)
        OP_LOAD: begin
          bus.Cnt_Load = 1'b1;
          bus.Cnt_In   = r_arg;
        end
        OP_UP: if (w_step) begin
`ifdef CNT_ARB_WRAP_EN
          if (bus.Cnt_High) begin
            bus.Cnt_Load = 1'b1;
            bus.Cnt_In   = '0;
          end else begin
            bus.Cnt_Up = 1'b1;
          end
`else
          bus.Cnt_Up = 1'b1;
`endif
        end
        OP_DOWN: if (w_step) begin
`ifdef CNT_ARB_WRAP_EN
          if (bus.Cnt_Low) begin
            bus.Cnt_Load = 1'b1;
            bus.Cnt_In   = '1;
          end else begin
            bus.Cnt_Down = 1'b1;
          end
`else
          bus.Cnt_Down = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// tb/tb_counter_cmd_arbiter.sv - self-checking bench for counter_cmd_arbiter with a 5-bit counter model
module tb_counter_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] cnt;
  logic       preset_en;
  logic [4:0] preset_val;

  int n_checks = 0;
  int n_errors = 0;

  counter_cmd_arbiter_if #(.WIDTH(5)) bus ();

  counter_cmd_arbiter #(.WIDTH(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counter the block drives; preset lets the bench place it at a start value.
  always @(posedge clk) begin
    if (preset_en)         cnt <= preset_val;
    else if (bus.Cnt_Load) cnt <= bus.Cnt_In;
    else if (bus.Cnt_Up)   cnt <= cnt + 5'd1;
    else if (bus.Cnt_Down) cnt <= cnt - 5'd1;
  end

  assign bus.Cnt_Value = cnt;
  assign bus.Cnt_High  = (cnt == 5'd31);
  assign bus.Cnt_Low   = (cnt == 5'd0);

  typedef struct {
    int         idx;
    logic [1:0] op;
    int         arg;
    int         start;
    int         res;
    int         sat;
    int         lat;
    int         pulses;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [18:0] all_outs();
    return {bus.Gnt0, bus.Gnt1, bus.Busy, bus.Done, bus.Done_Id, bus.Sat,
            bus.Result, bus.Cnt_In, bus.Cnt_Load, bus.Cnt_Up, bus.Cnt_Down};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input int v);
    preset_val = 5'(v);
    preset_en  = 1'b1;
    tick();
    preset_en  = 1'b0;
  endtask

  // Expected outcome from the command rules: how far the counter can move
  // before hitting its limit, and the cycle count from request to Done.
  task automatic ref_cmd(input int op, input int n, input int v,
                         output int res, output int sat, output int lat, output int pulses);
    sat = 0;
    case (op)
      0: begin res = n; lat = 2; pulses = 1; end
      3: begin res = v; lat = 2; pulses = 0; end
      default: begin : updn
`ifdef CNT_ARB_WRAP_EN
        res    = (op == 1) ? (v + n) % 32 : (v - n + 32) % 32;
        pulses = n;
        lat    = (n == 0) ? 2 : n + 1;
`else
        int room;
        room = (op == 1) ? 31 - v : v;
        if (n <= room) begin
          res    = (op == 1) ? v + n : v - n;
          pulses = n;
          lat    = (n == 0) ? 2 : n + 1;
        end else begin
          res    = (op == 1) ? 31 : 0;
          sat    = 1;
          pulses = room;
          lat    = room + 2;
        end
`endif
      end
    endcase
  endtask

  // Issues one command from an idle DUT and watches it to Done (bounded).
  task automatic run_cmd(input int idx, input logic [1:0] op, input int arg,
                         output int lat, output int pulses, output int res, output int sat,
                         output int did, output int gnt_bad, output int busy_bad, output int multi);
    lat = 0; pulses = 0; res = -1; sat = -1; did = -1;
    gnt_bad = 0; busy_bad = 0; multi = 0;
    if (idx == 0) begin
      bus.Req0 = 1'b1; bus.Op0 = op; bus.Arg0 = 5'(arg);
    end else begin
      bus.Req1 = 1'b1; bus.Op1 = op; bus.Arg1 = 5'(arg);
    end
    for (int c = 1; c <= 80; c++) begin
      tick();
      lat = c;
      if (c == 1) begin
        if (((idx == 0) ? bus.Gnt0 : bus.Gnt1) !== 1'b1) gnt_bad++;
        if (((idx == 0) ? bus.Gnt1 : bus.Gnt0) !== 1'b0) gnt_bad++;
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
      end else if (bus.Gnt0 || bus.Gnt1) begin
        gnt_bad++;
      end
      if (bus.Busy !== 1'b1) busy_bad++;
      if (int'(bus.Cnt_Load) + int'(bus.Cnt_Up) + int'(bus.Cnt_Down) > 1) multi++;
      if (bus.Cnt_Load || bus.Cnt_Up || bus.Cnt_Down) pulses++;
      if (bus.Done) begin
        res = int'(bus.Result); sat = int'(bus.Sat); did = int'(bus.Done_Id);
        break;
      end
    end
  endtask

  task automatic do_cmd(input string tag, input int idx, input logic [1:0] op, input int arg,
                        input int start, input int e_res, input int e_sat, input int e_lat,
                        input int e_pulses);
    int lat, pulses, res, sat, did, gnt_bad, busy_bad, multi;
    set_cnt(start);
    run_cmd(idx, op, arg, lat, pulses, res, sat, did, gnt_bad, busy_bad, multi);
    check({tag, ".result"},   res,      e_res);
    check({tag, ".sat"},      sat,      e_sat);
    check({tag, ".latency"},  lat,      e_lat);
    check({tag, ".pulses"},   pulses,   e_pulses);
    check({tag, ".done_id"},  did,      idx);
    check({tag, ".grant"},    gnt_bad,  0);
    check({tag, ".busy"},     busy_bad, 0);
    check({tag, ".onehot"},   multi,    0);
  endtask

  initial begin
    int r_res, r_sat, r_lat, r_pulses;
    int gseq[6], dseq[6], gcyc[6], dcyc[6];
    int ng, nd, g0, g1, outstanding, overlap, dones;
    int idx, op, arg, start;

`ifdef CNT_ARB_WRAP_EN
    vecs[2] = '{0, 2'b01, 5, 29, 2, 0, 6, 5};
    vecs[5] = '{1, 2'b10, 4, 2, 30, 0, 5, 4};
    vecs[8] = '{0, 2'b01, 1, 31, 0, 0, 2, 1};
`else
    vecs[2] = '{0, 2'b01, 5, 29, 31, 1, 4, 2};
    vecs[5] = '{1, 2'b10, 4, 2, 0, 1, 4, 2};
    vecs[8] = '{0, 2'b01, 1, 31, 31, 1, 2, 0};
`endif
    vecs[0] = '{0, 2'b00, 7, 0, 7, 0, 2, 1};
    vecs[1] = '{1, 2'b01, 5, 7, 12, 0, 6, 5};
    vecs[3] = '{1, 2'b01, 0, 12, 12, 0, 2, 0};
    vecs[4] = '{0, 2'b11, 9, 12, 12, 0, 2, 0};
    vecs[6] = '{0, 2'b10, 3, 20, 17, 0, 4, 3};
    vecs[7] = '{1, 2'b00, 31, 5, 31, 0, 2, 1};

    rst = 1'b1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.Op0 = 2'b11; bus.Op1 = 2'b11;
    bus.Arg0 = 5'd0; bus.Arg1 = 5'd0;
    preset_en = 1'b1; preset_val = 5'd0;
    repeat (2) tick();
    check("reset.outs_in_reset", int'(all_outs()), 0);
    rst = 1'b0;
    preset_en = 1'b0;
    tick();
    check("reset.outs_after", int'(all_outs()), 0);

    for (int i = 0; i < 9; i++) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].idx, vecs[i].op, vecs[i].arg, vecs[i].start,
             vecs[i].res, vecs[i].sat, vecs[i].lat, vecs[i].pulses);
    end

    // Reset mid-command: DOWN 10 from 3, reset during the second step.
    set_cnt(3);
    bus.Req0 = 1'b1; bus.Op0 = 2'b10; bus.Arg0 = 5'd10;
    tick();
    check("abort.gnt0", int'(bus.Gnt0), 1);
    check("abort.first_down", int'(bus.Cnt_Down), 1);
    bus.Req0 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort.gated_in_rst", int'({bus.Cnt_Load, bus.Cnt_Up, bus.Cnt_Down}), 0);
    tick();
    rst = 1'b0;
    check("abort.outs_after_rst", int'(all_outs()), 0);
    check("abort.cnt_held", int'(cnt), 2);
    dones = 0;
    repeat (5) begin
      tick();
      if (bus.Done || bus.Busy) dones++;
    end
    check("abort.no_done", dones, 0);
    check("abort.cnt_final", int'(cnt), 2);

    // Contention: both requesters hold Req for three commands each.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_cnt(5);
    bus.Op0 = 2'b01; bus.Arg0 = 5'd1;
    bus.Op1 = 2'b10; bus.Arg1 = 5'd1;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    ng = 0; nd = 0; g0 = 0; g1 = 0; outstanding = 0; overlap = 0;
    for (int c = 0; c < 200 && nd < 6; c++) begin
      tick();
      if (bus.Gnt0 && bus.Gnt1) overlap++;
      if (bus.Gnt0 || bus.Gnt1) begin
        if (outstanding != 0) overlap++;
        outstanding = 1;
        if (ng < 6) begin gseq[ng] = int'(bus.Gnt1); gcyc[ng] = c; end
        ng++;
        if (bus.Gnt0) begin g0++; if (g0 == 3) bus.Req0 = 1'b0; end
        if (bus.Gnt1) begin g1++; if (g1 == 3) bus.Req1 = 1'b0; end
      end
      if (bus.Done) begin
        if (outstanding == 0) overlap++;
        outstanding = 0;
        if (nd < 6) begin dseq[nd] = int'(bus.Done_Id); dcyc[nd] = c; end
        nd++;
      end
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    check("rr.grants", ng, 6);
    check("rr.dones", nd, 6);
    check("rr.overlap", overlap, 0);
    if (ng == 6 && nd == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("rr.grant%0d", i), gseq[i], i % 2);
        check($sformatf("rr.done_id%0d", i), dseq[i], i % 2);
      end
      for (int i = 0; i < 5; i++) begin
        check($sformatf("rr.gap%0d", i), gcyc[i+1] - dcyc[i], 2);
      end
    end
    tick();

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      idx   = int'($urandom_range(0, 1));
      op    = int'($urandom_range(0, 3));
      arg   = int'($urandom_range(0, 31));
      start = int'($urandom_range(0, 31));
      ref_cmd(op, arg, start, r_res, r_sat, r_lat, r_pulses);
      do_cmd($sformatf("rnd%0d", i), idx, 2'(op), arg, start, r_res, r_sat, r_lat, r_pulses);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
